input_data_scheduler: RTL and testbench
=======================================

Name: input_data_scheduler

Overview:
Sequences reads from the 1-bit input-feature ROM for the ELM hidden layer. On a start pulse it picks one training/test sample. For each hidden neuron in turn, it sweeps every feature bit of that sample. Each bit goes out on a valid/ready stream tagged with its feature index, its neuron index and first/last flags. It sits between the top-level ELM controller and the hidden-layer MAC. It drives the address of the asynchronous-read input memory wrapper directly.

Parameters:
NUM_FEAT, 16, feature bits per sample (>=2)
NUM_HIDDEN, 10, hidden neurons to sweep per sample (>=1)
NUM_SAMPLES, 16, samples stored in ROM; NUM_FEAT*NUM_SAMPLES <= 2**ADDR_W
ADDR_W, 8, ROM address width
FEAT_W, 4, width of feature index (clog2 NUM_FEAT)
NEUR_W, 4, width of neuron index (clog2 NUM_HIDDEN)
SAMP_W, 4, width of sample index

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a sample sweep
abort  in  1  synchronous cancel of the current sweep
sample_idx  in  SAMP_W  sample to sweep; sampled when start is accepted
mem_addr  out  ADDR_W  address to input memory wrapper
mem_data  in  1  asynchronous-read data for mem_addr, same cycle
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse after final handshake
err  out  1  one-cycle pulse when start is rejected (sample_idx >= NUM_SAMPLES)
out_valid  out  1  stream data valid
out_ready  in  1  downstream accepts
out_bit  out  1  feature bit
out_feat  out  FEAT_W  feature index of out_bit
out_neuron  out  NEUR_W  neuron index being served
out_first  out  1  out_feat==0 (start of neuron dot product)
out_last_feat  out  1  out_feat==NUM_FEAT-1
out_last_all  out  1  final element of the sweep

Behaviour:
- Reset: every output is 0. State is IDLE and all counters are 0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 with sample_idx<NUM_SAMPLES: latch base = sample_idx*NUM_FEAT (ADDR_W bits, no overflow by the parameter rule). Clear feat and neur. Go to RUN. busy=1 from the next cycle.
  - start=1 with sample_idx>=NUM_SAMPLES: err=1 for the next cycle only. Stay in IDLE.
- start is ignored while busy.
- mem_addr = base + feat (registered counters, combinational sum). It holds its last value in IDLE.
- RUN load rule: ld = !out_valid || out_ready. On ld:
  - Register mem_data into out_bit, feat into out_feat and neur into out_neuron.
  - Set the flags from the pre-increment counters and set out_valid=1.
  - Increment feat. It wraps to 0 at NUM_FEAT-1 and neur increments at the wrap.
  - If the loaded element is the last one (feat=NUM_FEAT-1, neur=NUM_HIDDEN-1), go to DRAIN.
- Stream rule: output registers are stable while out_valid && !out_ready. No element is skipped or duplicated. One element per cycle when out_ready stays high.
- DRAIN: on out_valid && out_ready, clear out_valid, go to IDLE and pulse done=1 for one cycle. busy drops in the same cycle done rises.
- Latency with out_ready=1 and start at cycle 0:
  - first out_valid at cycle 2;
  - last handshake at cycle NUM_FEAT*NUM_HIDDEN+1;
  - done at cycle NUM_FEAT*NUM_HIDDEN+2.
- abort (any state, priority over start and ld): next cycle is IDLE. out_valid=0, busy=0, counters cleared, no done.
- Simultaneous start and abort in IDLE: abort wins and start is dropped.
- Async rst mid-sweep: immediately clears all outputs. No done or err afterwards.

Decomposition:
- Package elm_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - default constants NUM_FEAT, NUM_HIDDEN, NUM_SAMPLES and the derived widths, shared with the input memory wrapper and the hidden-layer MAC.
- One sub-module, input_index_counter: the nested feat/neur counter with clear, enable, wrap and last outputs. The FSM and output register stay in the top module.

Test Plan:
- Basic sweep: rst, then start with sample_idx=3, out_ready=1. Required: mem_addr walks 48..63 ten times. Exactly 160 handshakes, with out_feat 0..15 per neuron and out_neuron 0..9. out_first every 16th beat, out_last_all only on beat 160. out_bit equals ROM[48+feat]. done pulse at cycle 162.
- Backpressure: out_ready toggled pseudo-randomly (50%) on sample 0. Required: 160 handshakes, identical data sequence to the out_ready=1 run, and outputs never change while valid && !ready.
- Range check: start with sample_idx=16. Required: err=1 for one cycle, busy stays 0, no out_valid, and mem_addr unchanged.
- Start while busy: a second start at beat 20 with sample_idx=5. Required: ignored, and the sweep of the original sample completes with 160 beats.
- Abort at beat 50, with out_valid high and out_ready=0. Required: next cycle out_valid=0 and busy=0, no done. A following start with sample_idx=1 gives a clean sweep from address 16, feat 0, neuron 0.
- Async rst asserted mid-cycle at beat 80. Required: all outputs 0 immediately. After release, the block is idle until start.

Source files
------------

// File: rtl/elm_pkg.sv
// Constants and state encoding shared by the ELM input path: memory wrapper, scheduler and hidden-layer MAC.
package elm_pkg;

   localparam int DEF_NUM_FEAT    = 16;
   localparam int DEF_NUM_HIDDEN  = 10;
   localparam int DEF_NUM_SAMPLES = 16;
   localparam int DEF_ADDR_W      = 8;
   localparam int DEF_FEAT_W      = $clog2(DEF_NUM_FEAT);
   localparam int DEF_NEUR_W      = $clog2(DEF_NUM_HIDDEN);
   localparam int DEF_SAMP_W      = $clog2(DEF_NUM_SAMPLES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/input_index_counter.sv
// Nested feature/neuron index counter: feature is the inner loop, neuron advances when feature wraps.
// last_all_o flags the final (feature, neuron) pair of a sweep.
module input_index_counter #(
   parameter int NUM_FEAT   = 16,
   parameter int NUM_HIDDEN = 10,
   parameter int FEAT_W     = 4,
   parameter int NEUR_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              en_i,
   output logic [FEAT_W-1:0] feat_o,
   output logic [NEUR_W-1:0] neur_o,
   output logic              last_feat_o,
   output logic              last_all_o
);

   logic [FEAT_W-1:0] feat_q, feat_d;
   logic [NEUR_W-1:0] neur_q, neur_d;

   assign feat_o      = feat_q;
   assign neur_o      = neur_q;
   assign last_feat_o = (feat_q == FEAT_W'(NUM_FEAT - 1));
   assign last_all_o  = last_feat_o && (neur_q == NEUR_W'(NUM_HIDDEN - 1));

   always_comb begin
      feat_d = feat_q;
      neur_d = neur_q;
      if (clr_i) begin
         feat_d = '0;
         neur_d = '0;
      end else if (en_i) begin
         if (last_feat_o) begin
            feat_d = '0;
            neur_d = last_all_o ? '0 : neur_q + 1'b1;
         end else begin
            feat_d = feat_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         feat_q <= '0;
         neur_q <= '0;
      end else begin
         feat_q <= feat_d;
         neur_q <= neur_d;
      end
   end

endmodule

// File: rtl/input_data_scheduler.sv
// Sweeps the feature bits of one ROM sample once per hidden neuron onto a valid/ready stream.
// Output register loads whenever it is empty or being drained, so a full-rate sink sees one bit per cycle.
module input_data_scheduler
   import elm_pkg::*;
#(
   parameter int NUM_FEAT    = DEF_NUM_FEAT,
   parameter int NUM_HIDDEN  = DEF_NUM_HIDDEN,
   parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int FEAT_W      = DEF_FEAT_W,
   parameter int NEUR_W      = DEF_NEUR_W,
   parameter int SAMP_W      = DEF_SAMP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [SAMP_W-1:0] sample_idx,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_bit,
   output logic [FEAT_W-1:0] out_feat,
   output logic [NEUR_W-1:0] out_neuron,
   output logic              out_first,
   output logic              out_last_feat,
   output logic              out_last_all
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              vld_q, vld_d, bit_q, bit_d, done_q, done_d, err_q, err_d;
   logic [FEAT_W-1:0] ofeat_q, ofeat_d;
   logic [NEUR_W-1:0] oneur_q, oneur_d;
   logic              first_q, first_d, lfeat_q, lfeat_d, lall_q, lall_d;

   logic              ld, cnt_clr, cnt_en;
   logic [FEAT_W-1:0] feat;
   logic [NEUR_W-1:0] neur;
   logic              last_feat, last_all;

   input_index_counter #(
      .NUM_FEAT  (NUM_FEAT),
      .NUM_HIDDEN(NUM_HIDDEN),
      .FEAT_W    (FEAT_W),
      .NEUR_W    (NEUR_W)
   ) u_idx (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (cnt_clr),
      .en_i       (cnt_en),
      .feat_o     (feat),
      .neur_o     (neur),
      .last_feat_o(last_feat),
      .last_all_o (last_all)
   );

   assign mem_addr      = base_q + ADDR_W'(feat);
   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign err           = err_q;
   assign out_valid     = vld_q;
   assign out_bit       = bit_q;
   assign out_feat      = ofeat_q;
   assign out_neuron    = oneur_q;
   assign out_first     = first_q;
   assign out_last_feat = lfeat_q;
   assign out_last_all  = lall_q;

   assign ld = (state_q == RUN) && (!vld_q || out_ready);

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      vld_d   = vld_q;
      bit_d   = bit_q;
      ofeat_d = ofeat_q;
      oneur_d = oneur_q;
      first_d = first_q;
      lfeat_d = lfeat_q;
      lall_d  = lall_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      // abort outranks both a fresh start and an in-flight load
      if (abort) begin
         state_d = IDLE;
         vld_d   = 1'b0;
         cnt_clr = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (32'(sample_idx) < NUM_SAMPLES) begin
                     base_d  = ADDR_W'(32'(sample_idx) * NUM_FEAT);
                     cnt_clr = 1'b1;
                     state_d = RUN;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            RUN: begin
               if (ld) begin
                  cnt_en  = 1'b1;
                  vld_d   = 1'b1;
                  bit_d   = mem_data;
                  ofeat_d = feat;
                  oneur_d = neur;
                  first_d = (feat == '0);
                  lfeat_d = last_feat;
                  lall_d  = last_all;
                  if (last_all) state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (vld_q && out_ready) begin
                  vld_d   = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         vld_q   <= 1'b0;
         bit_q   <= 1'b0;
         ofeat_q <= '0;
         oneur_q <= '0;
         first_q <= 1'b0;
         lfeat_q <= 1'b0;
         lall_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         vld_q   <= vld_d;
         bit_q   <= bit_d;
         ofeat_q <= ofeat_d;
         oneur_q <= oneur_d;
         first_q <= first_d;
         lfeat_q <= lfeat_d;
         lall_q  <= lall_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_input_data_scheduler.sv
// Scoreboard bench for input_data_scheduler: a sweep model queues expected beats, a monitor checks every handshake.
module tb_input_data_scheduler;

   localparam int NF = 16, NH = 10, NS = 16, AW = 8, FW = 4, NW = 4, SW = 5;
   localparam int BEATS = NF * NH;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0, abort = 1'b0, out_ready = 1'b0;
   logic [SW-1:0] sample_idx = '0;
   logic [AW-1:0] mem_addr;
   logic          mem_data, busy, done, err, out_valid, out_bit;
   logic [FW-1:0] out_feat;
   logic [NW-1:0] out_neuron;
   logic          out_first, out_last_feat, out_last_all;

   logic rom [0:255];
   assign mem_data = rom[mem_addr];

   typedef struct packed {
      logic          b;
      logic [FW-1:0] f;
      logic [NW-1:0] n;
      logic          first;
      logic          lf;
      logic          la;
   } beat_t;

   beat_t exp_q[$];
   int    tests = 0, fails = 0, beat_cnt = 0, done_cnt = 0;
   bit    rand_ready = 1'b0;

   always #5 clk = ~clk;

   input_data_scheduler #(
      .NUM_FEAT(NF), .NUM_HIDDEN(NH), .NUM_SAMPLES(NS),
      .ADDR_W(AW), .FEAT_W(FW), .NEUR_W(NW), .SAMP_W(SW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .sample_idx(sample_idx),
      .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done), .err(err),
      .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_feat(out_feat),
      .out_neuron(out_neuron), .out_first(out_first), .out_last_feat(out_last_feat),
      .out_last_all(out_last_all)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a sweep is every feature of the sample, repeated once per neuron.
   task automatic push_sweep(input int idx);
      beat_t e;
      for (int n = 0; n < NH; n++) begin
         for (int f = 0; f < NF; f++) begin
            e.b     = rom[idx * NF + f];
            e.f     = FW'(f);
            e.n     = NW'(n);
            e.first = (f == 0);
            e.lf    = (f == NF - 1);
            e.la    = (n == NH - 1) && (f == NF - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic pulse_start(input int idx);
      start      = 1'b1;
      sample_idx = SW'(idx);
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   task automatic wait_beats(input int n);
      int k = 0;
      while (beat_cnt < n && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      chk("beat_wait", beat_cnt >= n, 1);
   endtask

   task automatic wait_done(input int budget, output int dcyc, output int fvcyc);
      dcyc  = 0;
      fvcyc = 0;
      for (int n = 1; n <= budget && dcyc == 0; n++) begin
         @(negedge clk);
         if (out_valid && fvcyc == 0) fvcyc = n;
         if (done) begin
            dcyc = n;
            chk("busy_low_at_done", busy, 0);
         end
         @(posedge clk); #1;
      end
      chk("done_seen", dcyc != 0, 1);
      chk("done_one_cycle", done, 0);
   endtask

   function automatic longint all_outs();
      return {mem_addr, busy, done, err, out_valid, out_bit, out_feat, out_neuron,
              out_first, out_last_feat, out_last_all};
   endfunction

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: pops on every handshake and checks held outputs across stalls.
   initial begin
      beat_t cur, prev, e;
      bit    prev_stall;
      prev_stall = 1'b0;
      prev       = '0;
      forever begin
         @(negedge clk);
         cur = {out_bit, out_feat, out_neuron, out_first, out_last_feat, out_last_all};
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_hold", cur, prev);
               chk("stall_valid", out_valid, 1);
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
               beat_cnt++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat", cur, e);
               end
            end
            prev_stall = out_valid && !out_ready && !abort;
            prev       = cur;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc, fv, dsnap;
      logic [AW-1:0] addr_before;
      for (int i = 0; i < 256; i++) rom[i] = 1'($urandom_range(0, 1));

      repeat (3) @(posedge clk); #1;
      chk("reset_outputs", all_outs(), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_reset", busy, 0);

      // Basic full-rate sweep of sample 3
      out_ready = 1'b1;
      beat_cnt  = 0;
      push_sweep(3);
      pulse_start(3);
      chk("busy_after_start", busy, 1);
      chk("addr_first", mem_addr, 48);
      wait_done(1000, dc, fv);
      chk("first_valid_cycle", fv, 2);
      chk("done_cycle", dc, BEATS + 2);
      chk("beats_basic", beat_cnt, BEATS);
      chk("queue_empty_basic", exp_q.size(), 0);

      // Out-of-range sample is rejected
      addr_before = mem_addr;
      pulse_start(16);
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      chk("err_valid", out_valid, 0);
      chk("err_addr_hold", mem_addr, addr_before);
      @(posedge clk); #1;
      chk("err_one_cycle", err, 0);
      chk("err_still_idle", busy, 0);

      // Random backpressure on sample 0
      rand_ready = 1'b1;
      beat_cnt   = 0;
      push_sweep(0);
      pulse_start(0);
      wait_done(5000, dc, fv);
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      chk("beats_bp", beat_cnt, BEATS);
      chk("queue_empty_bp", exp_q.size(), 0);

      // Second start while busy is ignored
      beat_cnt = 0;
      push_sweep(7);
      pulse_start(7);
      wait_beats(20);
      pulse_start(5);
      wait_done(1000, dc, fv);
      chk("beats_busy_start", beat_cnt, BEATS);
      chk("queue_empty_busy_start", exp_q.size(), 0);

      // Abort while stalled
      beat_cnt = 0;
      push_sweep(9);
      pulse_start(9);
      wait_beats(50);
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk("abort_precond_valid", out_valid, 1);
      dsnap = done_cnt;
      abort = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      abort = 1'b1;
      pulse_start(2);
      abort = 1'b0;
      chk("abort_beats_start", busy, 0);
      repeat (5) begin @(posedge clk); #1; end
      chk("abort_no_done", done_cnt, dsnap);
      chk("abort_idle", busy, 0);

      out_ready = 1'b1;
      beat_cnt  = 0;
      push_sweep(1);
      pulse_start(1);
      chk("post_abort_addr", mem_addr, 16);
      wait_done(1000, dc, fv);
      chk("post_abort_done_cycle", dc, BEATS + 2);
      chk("beats_post_abort", beat_cnt, BEATS);

      // Asynchronous reset mid-sweep
      beat_cnt = 0;
      push_sweep(11);
      pulse_start(11);
      wait_beats(80);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", all_outs(), 0);
      exp_q.delete();
      dsnap = done_cnt;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      chk("post_reset_idle", all_outs(), 0);
      chk("post_reset_no_done", done_cnt, dsnap);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
